// File: rtl/pipeline_ctrl_if.sv
// Hazard-controller bundle: pipeline register fields in, stage controls and forwarding selects out.
// Latency: none, this is wiring only.
// Backpressure: none, the controller's outputs are the pipeline's backpressure.
// Ports: master = pipeline datapath side (drives hazard inputs, receives controls);
//        slave  = pipeline_ctrl (receives hazard inputs, drives controls).
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
) ();
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic             ex_write_reg;
    logic             ex_read_mem;
    logic [4:0]       mem_rd;
    logic [4:0]       wb_rd;
    logic             mem_write_reg;
    logic             wb_write_reg;
    logic             ex_branch_taken;
    logic             icache_ready;
    logic             dcache_ready;
    logic             stall_fetch;
    logic             stall_decode;
    logic             bubble_ex;
    logic             flush_id;
    logic             stall_back;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rs1, ex_rs2, ex_rd, ex_write_reg, ex_read_mem,
        output mem_rd, wb_rd, mem_write_reg, wb_write_reg,
        output ex_branch_taken, icache_ready, dcache_ready,
        input  stall_fetch, stall_decode, bubble_ex, flush_id, stall_back,
        input  fwd_a_sel, fwd_b_sel, state, stall_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rs1, ex_rs2, ex_rd, ex_write_reg, ex_read_mem,
        input  mem_rd, wb_rd, mem_write_reg, wb_write_reg,
        input  ex_branch_taken, icache_ready, dcache_ready,
        output stall_fetch, stall_decode, bubble_ex, flush_id, stall_back,
        output fwd_a_sel, fwd_b_sel, state, stall_count
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: stall, bubble, flush, freeze, forwarding.
// Latency: all controls combinational from state/cnt/inputs (0 cycles); state, cnt, stall_count registered.
// Backpressure: dcache not ready freezes the whole pipe; icache not ready holds fetch and flushes decode.
// Ports: clk, rst_h (async, active-high) plain; bus (pipeline_ctrl_if.slave) carries the register
//        indices/control bits in and stall_fetch/stall_decode/bubble_ex/flush_id/stall_back,
//        fwd_a_sel/fwd_b_sel, state and stall_count out.
module pipeline_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic           clk,
    input  logic           rst_h,
    pipeline_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [2:0] LP_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam bit         LP_MULTI  = (FLUSH_CYCLES > 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_cnt;
    logic [2:0]       w_cnt_nxt;
    logic [CNT_W-1:0] r_stall_count;

    logic w_lu;
    logic w_sf;
    logic w_sd;
    logic w_bx;
    logic w_fid;
    logic w_sb;

    // Memory stage wins over write-back because it holds the younger value.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       mem_we, input logic [4:0] mem_rd,
                                           input logic       wb_we,  input logic [4:0] wb_rd);
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs))
            return 2'b10;
        else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign w_lu = bus.ex_read_mem & bus.ex_write_reg & (bus.ex_rd != 5'd0) &
                  ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                   (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));

    always_comb begin
        w_sf        = 1'b0;
        w_sd        = 1'b0;
        w_bx        = 1'b0;
        w_fid       = 1'b0;
        w_sb        = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;

        if (r_state == ST_FLUSH) begin
            if (!bus.dcache_ready) begin
                // Freeze holds cnt so no squash cycle is lost to the stall.
                w_sf = 1'b1;
                w_sd = 1'b1;
                w_sb = 1'b1;
            end else if (bus.ex_branch_taken) begin
                w_fid = 1'b1;
                w_bx  = 1'b1;
                if (LP_MULTI) begin
                    w_state_nxt = ST_FLUSH;
                    w_cnt_nxt   = LP_RELOAD;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end else begin
                w_fid     = 1'b1;
                w_sf      = ~bus.icache_ready;
                w_cnt_nxt = r_cnt - 3'd1;
                if (r_cnt == 3'd1)
                    w_state_nxt = ST_RUN;
            end
        end else begin
            // RUN rules; MEM_WAIT with dcache_ready=1 resumes through the same path.
            w_state_nxt = ST_RUN;
            if (!bus.dcache_ready) begin
                w_sf        = 1'b1;
                w_sd        = 1'b1;
                w_sb        = 1'b1;
                w_state_nxt = ST_MEM_WAIT;
            end else if (bus.ex_branch_taken) begin
                w_fid = 1'b1;
                w_bx  = 1'b1;
                if (LP_MULTI) begin
                    w_state_nxt = ST_FLUSH;
                    w_cnt_nxt   = LP_RELOAD;
                end
            end else if (w_lu) begin
                w_sf = 1'b1;
                w_sd = 1'b1;
                w_bx = 1'b1;
            end else if (!bus.icache_ready) begin
                w_sf  = 1'b1;
                w_fid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_h) begin
        if (rst_h) begin
            r_state <= ST_RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Saturating so a long-running counter never reads back as a small value.
    always_ff @(posedge clk or posedge rst_h) begin
        if (rst_h)
            r_stall_count <= '0;
        else if (w_sd && (r_stall_count != {CNT_W{1'b1}}))
            r_stall_count <= r_stall_count + CNT_W'(1);
    end

    // Controls are masked while reset is high so they drop without waiting for a clock.
    assign bus.stall_fetch  = w_sf  & ~rst_h;
    assign bus.stall_decode = w_sd  & ~rst_h;
    assign bus.bubble_ex    = w_bx  & ~rst_h;
    assign bus.flush_id     = w_fid & ~rst_h;
    assign bus.stall_back   = w_sb  & ~rst_h;
    assign bus.fwd_a_sel    = rst_h ? 2'b00 :
        fwd_sel(bus.ex_rs1, bus.mem_write_reg, bus.mem_rd, bus.wb_write_reg, bus.wb_rd);
    assign bus.fwd_b_sel    = rst_h ? 2'b00 :
        fwd_sel(bus.ex_rs2, bus.mem_write_reg, bus.mem_rd, bus.wb_write_reg, bus.wb_rd);
    assign bus.state        = r_state;
    assign bus.stall_count  = r_stall_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed steps, expectations queued then popped at sample time.
// Two instances: FLUSH_CYCLES=2/CNT_W=32 for the main sequence, FLUSH_CYCLES=4/CNT_W=2 for
// counter saturation and reset in the middle of a long flush.
module tb_pipeline_ctrl;

    logic clk;
    logic rst_h;

    pipeline_ctrl_if #(.CNT_W(32)) bus ();
    pipeline_ctrl_if #(.CNT_W(2))  bus4 ();

    pipeline_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) u_dut (
        .clk   (clk),
        .rst_h (rst_h),
        .bus   (bus)
    );

    pipeline_ctrl #(.FLUSH_CYCLES(4), .CNT_W(2)) u_dut4 (
        .clk   (clk),
        .rst_h (rst_h),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        sf;
        logic        sd;
        logic        bx;
        logic        fid;
        logic        sb;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [1:0]  st;
        logic [31:0] sc;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    bit    dut_q[$];

    int          checks;
    int          errors;
    logic [31:0] exp_sc;
    logic [31:0] exp_sc4;

    function automatic exp_t observe(input bit d4);
        exp_t o;
        if (d4) begin
            o.sf  = bus4.stall_fetch;
            o.sd  = bus4.stall_decode;
            o.bx  = bus4.bubble_ex;
            o.fid = bus4.flush_id;
            o.sb  = bus4.stall_back;
            o.fa  = bus4.fwd_a_sel;
            o.fb  = bus4.fwd_b_sel;
            o.st  = bus4.state;
            o.sc  = 32'(bus4.stall_count);
        end else begin
            o.sf  = bus.stall_fetch;
            o.sd  = bus.stall_decode;
            o.bx  = bus.bubble_ex;
            o.fid = bus.flush_id;
            o.sb  = bus.stall_back;
            o.fa  = bus.fwd_a_sel;
            o.fb  = bus.fwd_b_sel;
            o.st  = bus.state;
            o.sc  = bus.stall_count;
        end
        return o;
    endfunction

    task automatic push_exp(input bit d4, input string tag,
                            input logic sf, input logic sd, input logic bx, input logic fid,
                            input logic sb, input logic [1:0] fa, input logic [1:0] fb,
                            input logic [1:0] st);
        exp_t e;
        e.sf  = sf;
        e.sd  = sd;
        e.bx  = bx;
        e.fid = fid;
        e.sb  = sb;
        e.fa  = fa;
        e.fb  = fb;
        e.st  = st;
        e.sc  = d4 ? exp_sc4 : exp_sc;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        dut_q.push_back(d4);
    endtask

    task automatic check_front();
        exp_t  e;
        exp_t  o;
        string t;
        bit    d;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        d = dut_q.pop_front();
        o = observe(d);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed {sf sd bx fid sb fa fb st sc}=%b %b %b %b %b %b %b %0d %0d expected %b %b %b %b %b %b %b %0d %0d",
                   t, o.sf, o.sd, o.bx, o.fid, o.sb, o.fa, o.fb, o.st, o.sc,
                   e.sf, e.sd, e.bx, e.fid, e.sb, e.fa, e.fb, e.st, e.sc);
        end
    endtask

    // Inputs are already driven; sample on the falling edge, then advance past the next rising edge.
    task automatic step(input bit d4, input string tag,
                        input logic sf, input logic sd, input logic bx, input logic fid,
                        input logic sb, input logic [1:0] fa, input logic [1:0] fb,
                        input logic [1:0] st);
        push_exp(d4, tag, sf, sd, bx, fid, sb, fa, fb, st);
        @(negedge clk);
        check_front();
        @(posedge clk);
        if (sd) begin
            if (d4) begin
                if (exp_sc4 != 32'd3)
                    exp_sc4 = exp_sc4 + 32'd1;
            end else begin
                exp_sc = exp_sc + 32'd1;
            end
        end
        #1;
    endtask

    task automatic chk_now(input bit d4, input string tag,
                           input logic sf, input logic sd, input logic bx, input logic fid,
                           input logic sb, input logic [1:0] fa, input logic [1:0] fb,
                           input logic [1:0] st);
        push_exp(d4, tag, sf, sd, bx, fid, sb, fa, fb, st);
        check_front();
    endtask

    task automatic idle_main();
        bus.id_rs1          = 5'd0;
        bus.id_rs2          = 5'd0;
        bus.id_use_rs1      = 1'b0;
        bus.id_use_rs2      = 1'b0;
        bus.ex_rs1          = 5'd0;
        bus.ex_rs2          = 5'd0;
        bus.ex_rd           = 5'd0;
        bus.ex_write_reg    = 1'b0;
        bus.ex_read_mem     = 1'b0;
        bus.mem_rd          = 5'd0;
        bus.wb_rd           = 5'd0;
        bus.mem_write_reg   = 1'b0;
        bus.wb_write_reg    = 1'b0;
        bus.ex_branch_taken = 1'b0;
        bus.icache_ready    = 1'b1;
        bus.dcache_ready    = 1'b1;
    endtask

    task automatic idle_4();
        bus4.id_rs1          = 5'd0;
        bus4.id_rs2          = 5'd0;
        bus4.id_use_rs1      = 1'b0;
        bus4.id_use_rs2      = 1'b0;
        bus4.ex_rs1          = 5'd0;
        bus4.ex_rs2          = 5'd0;
        bus4.ex_rd           = 5'd0;
        bus4.ex_write_reg    = 1'b0;
        bus4.ex_read_mem     = 1'b0;
        bus4.mem_rd          = 5'd0;
        bus4.wb_rd           = 5'd0;
        bus4.mem_write_reg   = 1'b0;
        bus4.wb_write_reg    = 1'b0;
        bus4.ex_branch_taken = 1'b0;
        bus4.icache_ready    = 1'b1;
        bus4.dcache_ready    = 1'b1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_sc  = 32'd0;
        exp_sc4 = 32'd0;
        rst_h   = 1'b0;
        idle_main();
        idle_4();

        // Reset with inputs that would otherwise freeze, branch and forward.
        #1 rst_h = 1'b1;
        bus.dcache_ready    = 1'b0;
        bus.ex_branch_taken = 1'b1;
        bus.mem_write_reg   = 1'b1;
        bus.mem_rd          = 5'd3;
        bus.ex_rs1          = 5'd3;
        bus.ex_rs2          = 5'd3;
        #1;
        chk_now(0, "reset_forced", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        idle_main();
        rst_h = 1'b0;
        step(0, "after_reset", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd0);

        // Load-use on rs1, then the dependent op forwards from memory.
        bus.ex_read_mem  = 1'b1;
        bus.ex_write_reg = 1'b1;
        bus.ex_rd        = 5'd5;
        bus.id_use_rs1   = 1'b1;
        bus.id_rs1       = 5'd5;
        step(0, "lu_stall", 1, 1, 1, 0, 0, 2'b00, 2'b00, 2'd0);
        idle_main();
        bus.ex_rs1        = 5'd5;
        bus.mem_rd        = 5'd5;
        bus.mem_write_reg = 1'b1;
        step(0, "lu_fwd", 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'd0);

        // Load-use through rs2; rd=0 and unused source never stall.
        idle_main();
        bus.ex_read_mem  = 1'b1;
        bus.ex_write_reg = 1'b1;
        bus.ex_rd        = 5'd9;
        bus.id_use_rs1   = 1'b1;
        bus.id_rs1       = 5'd3;
        bus.id_use_rs2   = 1'b1;
        bus.id_rs2       = 5'd9;
        step(0, "lu_rs2", 1, 1, 1, 0, 0, 2'b00, 2'b00, 2'd0);
        idle_main();
        bus.ex_read_mem  = 1'b1;
        bus.ex_write_reg = 1'b1;
        bus.ex_rd        = 5'd0;
        bus.id_use_rs1   = 1'b1;
        bus.id_rs1       = 5'd0;
        step(0, "lu_rd0", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd0);
        bus.ex_rd      = 5'd6;
        bus.id_rs1     = 5'd6;
        bus.id_use_rs1 = 1'b0;
        step(0, "lu_nouse", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd0);

        // Icache miss in RUN.
        idle_main();
        bus.icache_ready = 1'b0;
        step(0, "icache_miss", 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'd0);

        // Taken branch, FLUSH_CYCLES=2.
        idle_main();
        bus.ex_branch_taken = 1'b1;
        step(0, "br_T", 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'd0);
        bus.ex_branch_taken = 1'b0;
        step(0, "br_T1", 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'd1);
        step(0, "br_T2", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd0);

        // Icache miss during the squash cycle holds fetch.
        bus.ex_branch_taken = 1'b1;
        step(0, "bri_T", 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'd0);
        bus.ex_branch_taken = 1'b0;
        bus.icache_ready    = 1'b0;
        step(0, "flush_imiss", 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'd1);
        bus.icache_ready = 1'b1;
        step(0, "flush_imiss_done", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd0);

        // Dcache stall in the middle of a flush extends it.
        bus.ex_branch_taken = 1'b1;
        step(0, "brd_T", 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'd0);
        bus.ex_branch_taken = 1'b0;
        bus.dcache_ready    = 1'b0;
        for (int i = 0; i < 3; i++)
            step(0, "brd_freeze", 1, 1, 0, 0, 1, 2'b00, 2'b00, 2'd1);
        bus.dcache_ready = 1'b1;
        step(0, "brd_resume", 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'd1);
        step(0, "brd_done", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd0);

        // Forwarding priority and rd=0 guard.
        idle_main();
        bus.mem_rd        = 5'd7;
        bus.wb_rd         = 5'd7;
        bus.mem_write_reg = 1'b1;
        bus.wb_write_reg  = 1'b1;
        bus.ex_rs2        = 5'd7;
        step(0, "fwd_mem", 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'd0);
        bus.mem_write_reg = 1'b0;
        step(0, "fwd_wb", 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'd0);
        bus.mem_rd        = 5'd0;
        bus.wb_rd         = 5'd0;
        bus.mem_write_reg = 1'b1;
        bus.ex_rs2        = 5'd0;
        step(0, "fwd_rd0", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd0);
        idle_main();
        bus.wb_rd        = 5'd4;
        bus.wb_write_reg = 1'b1;
        bus.ex_rs1       = 5'd4;
        bus.ex_rs2       = 5'd4;
        step(0, "fwd_wb_both", 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'd0);

        // Dcache stall outranks branch and load-use; release with branch still high.
        idle_main();
        bus.ex_branch_taken = 1'b1;
        bus.ex_read_mem     = 1'b1;
        bus.ex_write_reg    = 1'b1;
        bus.ex_rd           = 5'd5;
        bus.id_use_rs1      = 1'b1;
        bus.id_rs1          = 5'd5;
        bus.dcache_ready    = 1'b0;
        step(0, "pri_freeze", 1, 1, 0, 0, 1, 2'b00, 2'b00, 2'd0);
        step(0, "pri_wait", 1, 1, 0, 0, 1, 2'b00, 2'b00, 2'd2);
        bus.dcache_ready = 1'b1;
        step(0, "pri_release", 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'd2);
        idle_main();
        step(0, "pri_flush", 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'd1);
        step(0, "pri_run", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd0);

        // MEM_WAIT release into a load-use stall.
        bus.dcache_ready = 1'b0;
        step(0, "mw_enter", 1, 1, 0, 0, 1, 2'b00, 2'b00, 2'd0);
        bus.dcache_ready = 1'b1;
        bus.ex_read_mem  = 1'b1;
        bus.ex_write_reg = 1'b1;
        bus.ex_rd        = 5'd12;
        bus.id_use_rs2   = 1'b1;
        bus.id_rs2       = 5'd12;
        step(0, "mw_lu", 1, 1, 1, 0, 0, 2'b00, 2'b00, 2'd2);
        idle_main();
        step(0, "mw_run", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd0);

        // 2-bit stall counter saturates at 3.
        bus4.dcache_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            step(1, "sat", 1, 1, 0, 0, 1, 2'b00, 2'b00, (i == 0) ? 2'd0 : 2'd2);
        bus4.dcache_ready = 1'b1;
        step(1, "sat_hold", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd2);

        // FLUSH_CYCLES=4 branch, reset in the middle of the flush.
        bus4.ex_branch_taken = 1'b1;
        step(1, "br4_T", 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'd0);
        bus4.ex_branch_taken = 1'b0;
        step(1, "br4_T1", 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'd1);
        bus4.icache_ready = 1'b0;
        rst_h   = 1'b1;
        exp_sc  = 32'd0;
        exp_sc4 = 32'd0;
        #1;
        chk_now(1, "rst4_async", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd0);
        chk_now(0, "rst_main_async", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd0);
        bus4.icache_ready = 1'b1;
        @(negedge clk);
        rst_h = 1'b0;
        @(posedge clk);
        #1;
        step(1, "rst4_after", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd0);
        step(1, "rst4_after2", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
